wallace_mac: RTL and testbench
==============================

// Module: wallace_mac
// PURPOSE
//  Downstream consumer of the 8x8 unsigned Wallace multiplier (module wallace, ports a,b,out).
//  Registers operand pairs, instantiates wallace, pipelines the 16-bit product and accumulates
//  frames of products (dot products) into a wide accumulator.
//  Frames are delimited by in_last. Results are returned over a valid/ready output handshake.
// PARAMETERS
//  ACC_W  24  accumulator/result width; legal range >= 16
//  CNT_W  8   width of the per-frame term counter
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand beat valid
//  in_ready   out  1      block accepts a beat; a beat transfers when in_valid && in_ready
//  a          in   8      unsigned multiplicand
//  b          in   8      unsigned multiplier
//  in_last    in   1      beat is the final term of the current frame
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes the result; transfers when out_valid && out_ready
//  acc_out    out  ACC_W  frame sum of a*b
//  term_cnt   out  CNT_W  beats in the frame; saturates at all-ones
//  ovf        out  1      accumulation carried out of ACC_W during the frame
// BEHAVIOUR
//  Reset: in_ready=0 during rst and 1 on the first cycle after; all other outputs, pipeline
//   valids, acc and counter = 0. State = ACCUM. Reset mid-frame discards in-flight beats.
//  Pipeline: beat accepted on edge k -> a_r/b_r/last1/v1 at edge k; prod_r=wallace(a_r,b_r),
//   last2, v2 at edge k+1; acc += {0,prod_r} at edge k+2 when v2. Bubbles (in_valid=0)
//   propagate as v=0; acc unchanged.
//  Result timing: when v2 && last2, at edge k+2:
//   - acc_out <= acc+prod_r, term_cnt <= final count, ovf <= final flag;
//   - out_valid <= 1; acc, running count and running ovf clear to 0.
//  FSM:
//   ACCUM: in_ready=1. Accepting an in_last beat -> DRAIN.
//   DRAIN: in_ready=0; wait for the last beat to reach accumulate -> HOLD. This happens on the
//    same edge that sets out_valid.
//   HOLD: out_valid=1; acc_out, term_cnt and ovf held stable. On out_valid && out_ready ->
//    ACCUM; out_valid falls and in_ready rises on that edge. A new frame never overlaps an
//    undrained result.
//  Single-beat frame (first beat carries in_last): acc_out = a*b, term_cnt = 1.
//  Width rule: product zero-extended to ACC_W+1; bit ACC_W of the sum sets running ovf
//   (sticky for the frame).
// CONFIGURATION
//  WALLACE_MAC_SAT_EN defined: on carry-out, acc saturates to 2^ACC_W-1 and stays there for the
//   rest of the frame; ovf=1.
//  Not defined: acc wraps modulo 2^ACC_W; ovf=1.
// TESTING
//  1 Single beat a=87,b=63,last=1 -> out_valid rises 2 edges after accept; acc_out=5481,
//    term_cnt=1, ovf=0.
//  2 Frame (87,63),(215,234),(231,135),(119,60 last) back-to-back -> acc_out=94116,
//    term_cnt=4, ovf=0.
//  3 Test 2 with in_valid toggled 1/0 every cycle -> identical result; in_ready=0 from
//    last-accept until handshake.
//  4 Test 1 with out_ready held 0 for 5 cycles -> out_valid/acc_out/term_cnt held stable;
//    on handshake, out_valid=0 and in_ready=1 on the next edge.
//  5 ACC_W=16, frame (255,255),(255,255 last) -> wrap: acc_out=64514, ovf=1;
//    with WALLACE_MAC_SAT_EN: acc_out=65535, ovf=1.
//  6 rst pulsed after 2 beats of a frame, then frame (3,4 last) -> pre-reset beats discarded;
//    acc_out=12, term_cnt=1, ovf=0.

Source files
------------

// File: rtl/wallace_mac.sv
// Wallace-tree 8x8 multiply-accumulate over in_last-delimited frames with a valid/ready result port.
// Optional macro WALLACE_MAC_SAT_EN: saturate the accumulator on carry-out instead of wrapping.

module wallace (
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] out
);
    // Word-level 3:2 compressor; the dropped top carry is beyond the 16-bit product range.
    function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                        input logic [15:0] z);
        logic [15:0] s;
        logic [15:0] c;
        s = x ^ y ^ z;
        c = ((x & y) | (x & z) | (y & z)) << 1;
        return {c, s};
    endfunction

    logic [15:0] w_pp [8];
    logic [15:0] w_s1a, w_c1a, w_s1b, w_c1b;
    logic [15:0] w_s2a, w_c2a, w_s2b, w_c2b;
    logic [15:0] w_s3, w_c3, w_s4, w_c4;

    always_comb begin
        for (int unsigned i = 0; i < 8; i++) begin
            w_pp[i] = b[i] ? (16'(a) << i) : '0;
        end
        {w_c1a, w_s1a} = csa(w_pp[0], w_pp[1], w_pp[2]);
        {w_c1b, w_s1b} = csa(w_pp[3], w_pp[4], w_pp[5]);
        {w_c2a, w_s2a} = csa(w_s1a, w_c1a, w_s1b);
        {w_c2b, w_s2b} = csa(w_c1b, w_pp[6], w_pp[7]);
        {w_c3, w_s3}   = csa(w_s2a, w_c2a, w_s2b);
        {w_c4, w_s4}   = csa(w_s3, w_c3, w_c2b);
        out            = w_s4 + w_c4;
    end
endmodule

module wallace_mac #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf
);
    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t           r_state, w_state_next;
    logic             w_accept;
    logic [7:0]       r_a, r_b;
    logic             r_v1, r_last1, r_v2, r_last2;
    logic [15:0]      w_prod, r_prod;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] r_acc, w_acc_next, r_acc_out;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, r_cnt_out;
    logic             r_ovf, w_ovf_next, r_ovf_out;

    wallace u_mul (.a(r_a), .b(r_b), .out(w_prod));

    assign w_accept = in_valid && in_ready;
    assign acc_out  = r_acc_out;
    assign term_cnt = r_cnt_out;
    assign ovf      = r_ovf_out;

    always_ff @(posedge clk) begin
        if (rst) r_state <= ACCUM;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ACCUM:   if (w_accept && in_last) w_state_next = DRAIN;
            DRAIN:   if (r_v2 && r_last2)     w_state_next = HOLD;
            HOLD:    if (out_ready)           w_state_next = ACCUM;
            default:                          w_state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ACCUM) && !rst;
        out_valid = (r_state == HOLD);
    end

    always_comb begin
        w_sum      = {1'b0, r_acc} + {{(ACC_W-15){1'b0}}, r_prod};
        w_ovf_next = r_ovf | w_sum[ACC_W];
`ifdef WALLACE_MAC_SAT_EN
        w_acc_next = w_ovf_next ? '1 : w_sum[ACC_W-1:0];
`else
        w_acc_next = w_sum[ACC_W-1:0];
`endif
        w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_v1      <= 1'b0;
            r_last1   <= 1'b0;
            r_prod    <= '0;
            r_v2      <= 1'b0;
            r_last2   <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_acc_out <= '0;
            r_cnt_out <= '0;
            r_ovf_out <= 1'b0;
        end else begin
            r_v1    <= w_accept;
            r_last1 <= w_accept && in_last;
            if (w_accept) begin
                r_a <= a;
                r_b <= b;
            end
            r_prod  <= w_prod;
            r_v2    <= r_v1;
            r_last2 <= r_last1;
            if (r_v2) begin
                if (r_last2) begin
                    r_acc_out <= w_acc_next;
                    r_cnt_out <= w_cnt_next;
                    r_ovf_out <= w_ovf_next;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_ovf     <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    r_cnt <= w_cnt_next;
                    r_ovf <= w_ovf_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_wallace_mac.sv
// Scoreboard bench for wallace_mac: a 24-bit instance for framing/handshake and a 16-bit one for overflow.

module tb_wallace_mac;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [7:0]  a = '0, b = '0;
    logic        in_ready, out_valid, ovf;
    logic [23:0] acc_out;
    logic [7:0]  term_cnt;

    logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
    logic [7:0]  s_a = '0, s_b = '0;
    logic        s_in_ready, s_out_valid, s_ovf;
    logic [15:0] s_acc_out;
    logic [7:0]  s_term_cnt;

    wallace_mac #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .term_cnt(term_cnt), .ovf(ovf)
    );

    wallace_mac #(.ACC_W(16), .CNT_W(8)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .a(s_a), .b(s_b),
        .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .acc_out(s_acc_out), .term_cnt(s_term_cnt), .ovf(s_ovf)
    );

    typedef struct packed {
        logic [23:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } res_t;

    res_t       sb[$];
    logic [7:0] fa [8];
    logic [7:0] fb [8];
    int         n_tests = 0;
    int         n_fail  = 0;

    // Drives n beats from fa/fb (optionally with a bubble before each beat after the first)
    // and pushes the frame result computed by a 24-bit reference model.
    task automatic send_frame(input int n, input bit gap);
        longint macc = 0;
        logic   movf = 1'b0;
        int     mcnt = 0;
        res_t   e;
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL in_ready_beat%0d: got %b expected 1", i, in_ready);
            end
            in_valid = 1'b1;
            a        = fa[i];
            b        = fb[i];
            in_last  = (i == n - 1);
            macc     = macc + longint'(fa[i]) * longint'(fb[i]);
            if (macc >= 64'd16777216) begin
                movf = 1'b1;
`ifdef WALLACE_MAC_SAT_EN
                macc = 64'd16777215;
`else
                macc = macc - 64'd16777216;
`endif
            end
            if (mcnt < 255) mcnt++;
        end
        e.acc = macc[23:0];
        e.cnt = mcnt[7:0];
        e.ovf = movf;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called one negedge after the last accept: checks latency, in_ready low, result, hold, handshake.
    task automatic wait_result(input int hold);
        int   t = 0;
        res_t e;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && t < 20) begin
            n_tests++;
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL in_ready_drain: got %b expected 0", in_ready);
            end
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (t != 2) begin
            n_fail++;
            $display("FAIL result_latency: got %0d edges expected 2", t);
            if (t >= 20) return;
        end
        e = sb.pop_front();
        for (int h = 0; h <= hold; h++) begin
            n_tests++;
            if (out_valid !== 1'b1 || acc_out !== e.acc || term_cnt !== e.cnt ||
                ovf !== e.ovf || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL result_hold%0d: got v=%b acc=%0d cnt=%0d ovf=%b rdy=%b expected v=1 acc=%0d cnt=%0d ovf=%b rdy=0",
                         h, out_valid, acc_out, term_cnt, ovf, in_ready, e.acc, e.cnt, e.ovf);
            end
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic load_frame4();
        fa[0] = 8'd87;  fb[0] = 8'd63;
        fa[1] = 8'd215; fb[1] = 8'd234;
        fa[2] = 8'd231; fb[2] = 8'd135;
        fa[3] = 8'd119; fb[3] = 8'd60;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== 24'd0 ||
            term_cnt !== 8'd0 || ovf !== 1'b0 || s_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b v=%b acc=%0d cnt=%0d ovf=%b expected all 0",
                     in_ready, out_valid, acc_out, term_cnt, ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || s_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got in_ready=%b/%b expected 1/1", in_ready, s_in_ready);
        end
    endtask

    task automatic test_single();
        fa[0] = 8'd87; fb[0] = 8'd63;
        send_frame(1, 1'b0);
        wait_result(0);
    endtask

    task automatic test_back_to_back();
        load_frame4();
        send_frame(4, 1'b0);
        wait_result(0);
    endtask

    task automatic test_bubbles();
        load_frame4();
        send_frame(4, 1'b1);
        wait_result(0);
    endtask

    task automatic test_backpressure();
        fa[0] = 8'd87; fb[0] = 8'd63;
        send_frame(1, 1'b0);
        wait_result(5);
    endtask

    task automatic test_wrap();
        int     t = 0;
        longint sum;
        logic [15:0] e_acc;
        sum = 2 * longint'(255) * longint'(255);
`ifdef WALLACE_MAC_SAT_EN
        e_acc = 16'hFFFF;
`else
        e_acc = 16'(sum - 65536);
`endif
        @(negedge clk);
        s_in_valid = 1'b1; s_a = 8'd255; s_b = 8'd255; s_in_last = 1'b0;
        @(negedge clk);
        s_in_last = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0; s_in_last = 1'b0;
        while (s_out_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (s_out_valid !== 1'b1 || s_acc_out !== e_acc || s_ovf !== 1'b1 || s_term_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL wrap16: got v=%b acc=%0d ovf=%b cnt=%0d expected v=1 acc=%0d ovf=1 cnt=2",
                     s_out_valid, s_acc_out, s_ovf, s_term_cnt, e_acc);
        end
        s_out_ready = 1'b1;
        @(negedge clk);
        s_out_ready = 1'b0;
        n_tests++;
        if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap16_handshake: got v=%b rdy=%b expected 0/1", s_out_valid, s_in_ready);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        in_valid = 1'b1; a = 8'd10; b = 8'd10; in_last = 1'b0;
        @(negedge clk);
        a = 8'd20;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midframe_reset_valid: got %b expected 0", out_valid);
        end
        fa[0] = 8'd3; fb[0] = 8'd4;
        send_frame(1, 1'b0);
        wait_result(0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bubbles();
        test_backpressure();
        test_wrap();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
